// File: rtl/grf_wport_arb.sv
// ---------------------------------------------------------------------------
// grf_wport_arb
//   Round-robin arbiter for the single write port of the register file, with
//   a one-cycle registered write stage and a per-register busy scoreboard.
//
//   Ports
//     i_clk, i_rst_b     clock (rising edge) / asynchronous active-low reset
//     i_clk_en           global enable; low freezes every register here
//     i_req_valid/ready  NREQ writeback requesters, one-hot grant in ready
//     i_req_addr/wen/data  per-requester payload, requester k at slice k
//     i_rsv_valid/addr   issue logic reserving a destination register
//     o_rsv_ready        reservation accepted this cycle
//     o_busy             scoreboard, bit r = write to Rr outstanding
//     o_rf_*             registered write port toward the register file
// ---------------------------------------------------------------------------
module grf_wport_arb #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_b,
    input  logic                   i_clk_en,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    input  logic [NREQ*AW-1:0]     i_req_addr,
    input  logic [NREQ*DW/8-1:0]   i_req_wen,
    input  logic [NREQ*DW-1:0]     i_req_data,
    input  logic                   i_rsv_valid,
    input  logic [AW-1:0]          i_rsv_addr,
    output logic                   o_rsv_ready,
    output logic [2**AW-1:0]       o_busy,
    output logic [AW-1:0]          o_rf_waddr,
    output logic [DW/8-1:0]        o_rf_wen,
    output logic [DW-1:0]          o_rf_din,
    output logic                   o_rf_cs_b
);

    localparam int BW   = DW / 8;
    localparam int NREG = 2 ** AW;
    localparam int PW   = $clog2(NREQ);

    logic [PW-1:0]   r_rr_ptr;
    logic [AW-1:0]   r_rf_waddr;
    logic [BW-1:0]   r_rf_wen;
    logic [DW-1:0]   r_rf_din;
    logic            r_rf_cs_b;
    logic            r_clr_pend;   // stage holds a transfer (write or release)
    logic [NREG-1:0] r_busy;

    logic [PW-1:0]   w_gnt_idx;
    logic            w_gnt_any;
    logic [PW-1:0]   w_cand;
    logic            w_xfer;
    logic [PW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_sel_addr;
    logic [BW-1:0]   w_sel_wen;
    logic [DW-1:0]   w_sel_data;
    logic            w_rsv_ok;
    logic [NREG-1:0] w_busy_nxt;

    // Round-robin search: first valid requester at or after the pointer,
    // wrapping modulo NREQ (NREQ need not be a power of two).
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = PW'((int'(r_rr_ptr) + i) % NREQ);
            if (!w_gnt_any && i_req_valid[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // Grants are suppressed while frozen or held in reset.
    assign w_xfer    = w_gnt_any & i_clk_en & i_rst_b;
    assign w_ptr_nxt = (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);

    always_comb begin
        o_req_ready = '0;
        if (w_xfer) begin
            o_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_wen  = '0;
        w_sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt_idx == PW'(k)) begin
                w_sel_addr = i_req_addr[k*AW +: AW];
                w_sel_wen  = i_req_wen[k*BW +: BW];
                w_sel_data = i_req_data[k*DW +: DW];
            end
        end
    end

    // A register still busy is refused, including the cycle its pending write
    // is presented to the file; the retry succeeds one cycle later.
    assign w_rsv_ok    = i_clk_en & ~r_busy[i_rsv_addr];
    assign o_rsv_ready = w_rsv_ok;

    // Clear from the staged transfer first, then the new reservation, so a
    // reservation of a register that was written untracked still sticks.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_clr_pend) begin
            w_busy_nxt[r_rf_waddr] = 1'b0;
        end
        if (i_rsv_valid && w_rsv_ok) begin
            w_busy_nxt[i_rsv_addr] = 1'b1;
        end
    end

    // Write stage. A zero-enable transfer is a release: it still clears the
    // scoreboard through r_clr_pend but never selects the file.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_rr_ptr   <= '0;
            r_rf_waddr <= '0;
            r_rf_wen   <= '0;
            r_rf_din   <= '0;
            r_rf_cs_b  <= 1'b1;
            r_clr_pend <= 1'b0;
        end else if (i_clk_en) begin
            r_clr_pend <= w_xfer;
            if (w_xfer) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_rf_waddr <= w_sel_addr;
                r_rf_wen   <= w_sel_wen;
                r_rf_din   <= w_sel_data;
                r_rf_cs_b  <= ~|w_sel_wen;
            end else begin
                r_rf_wen   <= '0;
                r_rf_cs_b  <= 1'b1;
            end
        end
    end

    // NOTE: the scoreboard is a flop array, not a RAM, so it is reset like any
    // other register; a stale busy bit after reset would stall issue forever.
    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_busy <= '0;
        end else if (i_clk_en) begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_rf_waddr = r_rf_waddr;
    assign o_rf_wen   = r_rf_wen;
    assign o_rf_din   = r_rf_din;
    assign o_rf_cs_b  = r_rf_cs_b;

endmodule
